// File: rtl/cdc_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdc_req_arbiter
// Purpose  : Two-port round-robin request arbiter in front of a single
//            request/response CDC channel. One transaction is outstanding at
//            a time: IDLE -> REQ -> WAIT -> RESP -> IDLE.
// Options  : CDC_ARB_TIMEOUT_EN - response timeout with synthetic
//            32'hDEAD_BEEF reply and drop of the late channel response.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_req_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
) (
  input  logic        clk1,
  input  logic        rst_ck1,
  // requester 0
  input  logic        req_vld_p0,
  output logic        req_rdy_p0,
  input  logic [6:0]  req_addr_p0,
  input  logic [31:0] req_data_p0,
  input  logic [1:0]  req_op_p0,
  output logic        resp_vld_p0,
  input  logic        resp_rdy_p0,
  output logic [6:0]  resp_addr_p0,
  output logic [31:0] resp_data_p0,
  output logic [1:0]  resp_op_p0,
  // requester 1
  input  logic        req_vld_p1,
  output logic        req_rdy_p1,
  input  logic [6:0]  req_addr_p1,
  input  logic [31:0] req_data_p1,
  input  logic [1:0]  req_op_p1,
  output logic        resp_vld_p1,
  input  logic        resp_rdy_p1,
  output logic [6:0]  resp_addr_p1,
  output logic [31:0] resp_data_p1,
  output logic [1:0]  resp_op_p1,
  // CDC channel side
  output logic        m_req_vld,
  input  logic        m_req_rdy,
  output logic [6:0]  m_req_addr,
  output logic [31:0] m_req_data,
  output logic [1:0]  m_req_op,
  input  logic        m_resp_vld,
  output logic        m_resp_rdy,
  input  logic [6:0]  m_resp_addr,
  input  logic [31:0] m_resp_data,
  input  logic [1:0]  m_resp_op,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_last_grant;   // 1 -> port 1 was granted last, port 0 wins a tie
  logic        r_owner;        // port that owns the outstanding transaction
  logic [6:0]  r_req_addr;
  logic [31:0] r_req_data;
  logic [1:0]  r_req_op;
  logic [6:0]  r_resp_addr;
  logic [31:0] r_resp_data;
  logic [1:0]  r_resp_op;
  logic        r_m_req_vld;
  logic        r_m_resp_rdy;
  logic        r_resp_vld_p0;
  logic        r_resp_vld_p1;
  logic        r_busy;

  logic        w_drop;         // a timed-out response is still owed by the channel
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_resp_fire;

`ifdef CDC_ARB_TIMEOUT_EN
  logic        r_drop_pending;
  logic [15:0] r_tmo_cnt;
  logic [15:0] w_tmo_cnt_nxt;

  assign w_drop        = r_drop_pending;
  assign w_tmo_cnt_nxt = r_tmo_cnt + 16'd1;
`else
  logic        w_unused_tmo;

  assign w_drop       = 1'b0;
  assign w_unused_tmo = ^TIMEOUT_CYCLES;
`endif

  // Grant: a lone requester wins; on a tie the port not granted last wins.
  // Nothing is granted while a dropped response is still outstanding.
  assign w_gnt0 = (r_state == S_IDLE) && !w_drop && req_vld_p0 &&
                  (!req_vld_p1 || r_last_grant);
  assign w_gnt1 = (r_state == S_IDLE) && !w_drop && req_vld_p1 &&
                  (!req_vld_p0 || !r_last_grant);

  assign w_resp_fire = (r_resp_vld_p0 && resp_rdy_p0) ||
                       (r_resp_vld_p1 && resp_rdy_p1);

  assign req_rdy_p0   = w_gnt0;
  assign req_rdy_p1   = w_gnt1;
  assign m_req_vld    = r_m_req_vld;
  assign m_req_addr   = r_req_addr;
  assign m_req_data   = r_req_data;
  assign m_req_op     = r_req_op;
  assign m_resp_rdy   = r_m_resp_rdy;
  assign busy         = r_busy;

  // Only the owning port sees the response; the other port reads all zeros.
  assign resp_vld_p0  = r_resp_vld_p0;
  assign resp_addr_p0 = r_resp_vld_p0 ? r_resp_addr : 7'd0;
  assign resp_data_p0 = r_resp_vld_p0 ? r_resp_data : 32'd0;
  assign resp_op_p0   = r_resp_vld_p0 ? r_resp_op   : 2'd0;
  assign resp_vld_p1  = r_resp_vld_p1;
  assign resp_addr_p1 = r_resp_vld_p1 ? r_resp_addr : 7'd0;
  assign resp_data_p1 = r_resp_vld_p1 ? r_resp_data : 32'd0;
  assign resp_op_p1   = r_resp_vld_p1 ? r_resp_op   : 2'd0;

  // Transaction FSM with all handshake outputs registered on the transitions.
  always_ff @(posedge clk1) begin
    if (rst_ck1) begin
      r_state       <= S_IDLE;
      r_last_grant  <= 1'b1;
      r_owner       <= 1'b0;
      r_req_addr    <= 7'd0;
      r_req_data    <= 32'd0;
      r_req_op      <= 2'd0;
      r_resp_addr   <= 7'd0;
      r_resp_data   <= 32'd0;
      r_resp_op     <= 2'd0;
      r_m_req_vld   <= 1'b0;
      r_m_resp_rdy  <= 1'b0;
      r_resp_vld_p0 <= 1'b0;
      r_resp_vld_p1 <= 1'b0;
      r_busy        <= 1'b0;
`ifdef CDC_ARB_TIMEOUT_EN
      r_drop_pending <= 1'b0;
      r_tmo_cnt      <= 16'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_owner      <= w_gnt1;
            r_last_grant <= w_gnt1;
            r_req_addr   <= w_gnt1 ? req_addr_p1 : req_addr_p0;
            r_req_data   <= w_gnt1 ? req_data_p1 : req_data_p0;
            r_req_op     <= w_gnt1 ? req_op_p1   : req_op_p0;
            r_m_req_vld  <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_REQ;
          end
        end
        S_REQ: begin
          if (m_req_rdy) begin
            r_m_req_vld  <= 1'b0;
            r_m_resp_rdy <= 1'b1;
            r_state      <= S_WAIT;
`ifdef CDC_ARB_TIMEOUT_EN
            r_tmo_cnt    <= 16'd0;
`endif
          end
        end
        S_WAIT: begin
          if (m_resp_vld) begin
            r_resp_addr   <= m_resp_addr;
            r_resp_data   <= m_resp_data;
            r_resp_op     <= m_resp_op;
            r_m_resp_rdy  <= 1'b0;
            r_resp_vld_p0 <= !r_owner;
            r_resp_vld_p1 <= r_owner;
            r_state       <= S_RESP;
          end
`ifdef CDC_ARB_TIMEOUT_EN
          else if (w_tmo_cnt_nxt == TIMEOUT_CYCLES) begin
            // Synthesize an error reply; m_resp_rdy stays high to eat the late one.
            r_resp_addr    <= r_req_addr;
            r_resp_data    <= 32'hDEAD_BEEF;
            r_resp_op      <= 2'b11;
            r_drop_pending <= 1'b1;
            r_resp_vld_p0  <= !r_owner;
            r_resp_vld_p1  <= r_owner;
            r_tmo_cnt      <= w_tmo_cnt_nxt;
            r_state        <= S_RESP;
          end else begin
            r_tmo_cnt      <= w_tmo_cnt_nxt;
          end
`endif
        end
        S_RESP: begin
          if (w_resp_fire) begin
            r_resp_vld_p0 <= 1'b0;
            r_resp_vld_p1 <= 1'b0;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef CDC_ARB_TIMEOUT_EN
      // The late response of a timed-out transaction is accepted and discarded.
      if (r_drop_pending && m_resp_vld && (r_state != S_WAIT)) begin
        r_drop_pending <= 1'b0;
        r_m_resp_rdy   <= 1'b0;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: doc/cdc_req_arbiter.md
CDC_REQ_ARBITER -- requirements
Module: cdc_req_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd1024, response-timeout limit in clk1 cycles (used only with CDC_ARB_TIMEOUT_EN).
REQ-002 The block SHALL have one clock and a synchronous, active-high reset: clk1 is the clock and rst_ck1 the reset.
REQ-003 The block SHALL have these ports:
- clk1  in  1  clock
- rst_ck1  in  1  synchronous active-high reset
- req_vld_pN  in  1  requester N (N=0,1) request valid
- req_rdy_pN  out  1  requester N request ready
- req_addr_pN  in  7  request address
- req_data_pN  in  32  request data
- req_op_pN  in  2  request op
- resp_vld_pN  out  1  response valid to requester N
- resp_rdy_pN  in  1  requester N response ready
- resp_addr_pN  out  7  response address
- resp_data_pN  out  32  response data
- resp_op_pN  out  2  response op
- m_req_vld / m_req_rdy  out/in  1  request handshake toward the CDC channel
- m_req_addr / m_req_data / m_req_op  out  7/32/2  request payload
- m_resp_vld / m_resp_rdy  in/out  1  response handshake from the CDC channel
- m_resp_addr / m_resp_data / m_resp_op  in  7/32/2  response payload
- busy  out  1  transaction in flight (state != IDLE)

Function
REQ-004 The FSM SHALL have states IDLE, REQ, WAIT and RESP, with exactly one transaction outstanding at any time.
REQ-005 In IDLE, the grant SHALL go to the single valid requester; if both are valid, it SHALL go to the requester not recorded in last_grant (round-robin); req_rdy_pN=1 only for the granted N.
REQ-006 On a req fire in IDLE, the block SHALL register the 41-bit payload {addr,data,op} and owner id, update last_grant, and go to REQ next cycle.
REQ-007 In REQ, the block SHALL drive m_req_vld=1 with the registered payload, and the payload SHALL stay stable until m_req_rdy=1; then go to WAIT.
REQ-008 In WAIT, the block SHALL hold m_resp_rdy=1; on m_resp_vld=1 it SHALL register the response payload and go to RESP.
REQ-009 In RESP, the block SHALL assert resp_vld for the owner only, with the registered response, and the other port's resp outputs SHALL be 0; on owner resp_rdy=1 go to IDLE.
REQ-010 Minimum latency from req fire to resp_vld SHALL be 3 cycles when m_req_rdy=1 and m_resp_vld=1 arrive immediately.
REQ-011 req_rdy_pN SHALL be 0 in every state except IDLE, and m_resp_rdy SHALL be 0 outside WAIT (except REQ-017).
REQ-012 A new request SHALL be accepted in the same cycle RESP returns to IDLE at the earliest, i.e. the cycle after the resp fire.
REQ-013 An m_resp_vld arriving outside WAIT SHALL be ignored (not acknowledged) without CDC_ARB_TIMEOUT_EN.

Reset
REQ-014 While rst_ck1=1 at a clk1 edge: state=IDLE, last_grant=1 (port 0 wins first tie), payload/response registers=0, all vld/rdy outputs=0, busy=0, timeout counter=0, drop_pending=0.
REQ-015 Reset asserted mid-transaction SHALL abandon it without issuing any response; the first post-reset grant follows REQ-005.

Configuration
REQ-016 With CDC_ARB_TIMEOUT_EN defined, a 16-bit counter SHALL clear on WAIT entry and increment each WAIT cycle; when it reaches TIMEOUT_CYCLES with no m_resp_vld, the block SHALL load response {registered addr, 32'hDEAD_BEEF, 2'b11}, set drop_pending and go to RESP.
REQ-017 With drop_pending=1, m_resp_rdy SHALL be 1 in all states; the next m_resp_vld SHALL be consumed and discarded, clearing drop_pending; IDLE SHALL grant nothing while drop_pending=1.
REQ-018 Without CDC_ARB_TIMEOUT_EN, the counter and drop_pending SHALL not exist and WAIT SHALL wait indefinitely.

Verification
REQ-019 Single request: p0 sends addr 7'h10, data 32'h1234_5678, op 2'b10, m_req_rdy=1 and m_resp_vld=1 immediately -> m_req payload matches; resp_vld_p0 3 cycles after the fire with echoed response; resp_vld_p1 stays 0.
REQ-020 Tie after reset: p0 and p1 both valid continuously for 4 transactions -> grant order p0,p1,p0,p1.
REQ-021 Backpressure: m_req_rdy low for 5 cycles, then resp_rdy_p1 low for 3 cycles -> payloads stable throughout, no second grant, busy=1 until the resp fire.
REQ-022 Reset in WAIT: rst_ck1 pulsed 1 cycle -> all outputs 0 next cycle, no resp_vld issued, next request served normally.
REQ-023 Timeout (macro on, TIMEOUT_CYCLES=8): no m_resp_vld -> after 8 WAIT cycles p0 receives data 32'hDEAD_BEEF, op 2'b11; late m_resp_vld is acknowledged and dropped; the queued p1 request is granted only afterwards.
